eth_tx_app_gen: RTL and testbench

- Synthesisable, parametrised packet source that drives the application side of eth_tx.
- Sequences burst requests from a runtime config: length sweep, inter-packet gap, optional cancel injection, sent/cancelled counters.
- Used for on-chip loopback and regression traffic in place of a bench-driven task.
- Sits between a control/CSR block and eth_tx (app_* interface).

---
 rtl/eth_tx_app_gen.sv | 269 ++++++++++++++++++++++++++
 tb/tb_eth_tx_app_gen.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_app_gen.sv
// eth_tx_app_gen: configurable packet source for the eth_tx application
// interface. Sweeps packet lengths, inserts inter-packet gaps, can inject a
// single mid-packet cancel, and counts sent/cancelled packets.
module eth_tx_app_gen #(
  parameter int DATA_W         = 16,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int LEN_W          = $clog2(KEEP_W + 1),
  parameter int BLOCK_N        = 8,
  parameter int APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1),
  parameter int PKT_LEN_W      = 16,
  parameter int UDP_CS_W       = 16,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [CNT_W-1:0]          cfg_pkt_n_i,
  input  logic [PKT_LEN_W-1:0]      cfg_len_i,
  input  logic [PKT_LEN_W-1:0]      cfg_len_step_i,
  input  logic [PKT_LEN_W-1:0]      cfg_len_max_i,
  input  logic [7:0]                cfg_gap_i,
  input  logic                      cfg_cancel_en_i,
  input  logic [CNT_W-1:0]          cfg_cancel_idx_i,
  input  logic [PKT_LEN_W-1:0]      cfg_cancel_beat_i,
  output logic                      app_early_v_o,
  input  logic                      app_ready_v_i,
  output logic                      app_cancel_o,
  output logic [DATA_W-1:0]         app_data_o,
  output logic [LEN_W-1:0]          app_len_o,
  output logic [PKT_LEN_W-1:0]      app_pkt_len_o,
  output logic [UDP_CS_W-1:0]       app_cs_o,
  output logic                      app_last_o,
  output logic                      app_last_block_next_o,
  output logic [APP_LAST_LEN_W-1:0] app_last_block_next_len_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_W-1:0]          pkt_sent_o,
  output logic [CNT_W-1:0]          pkt_cancel_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_LAST,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W:0] CNT_ONE = 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     p_q, p_d;
  logic [PKT_LEN_W-1:0] beat_q, beat_d;
  logic [7:0]           gap_q, gap_d;
  logic [PKT_LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]     sent_q, sent_d;
  logic [CNT_W-1:0]     canc_q, canc_d;

  // Burst configuration captured at start so the CSR side may change freely.
  logic [CNT_W-1:0]     pkt_n_q;
  logic [PKT_LEN_W-1:0] len0_q;
  logic [PKT_LEN_W-1:0] step_q;
  logic [PKT_LEN_W-1:0] max_q;
  logic [7:0]           gap_cfg_q;
  logic                 cancel_en_q;
  logic [CNT_W-1:0]     cancel_idx_q;
  logic [PKT_LEN_W-1:0] cancel_beat_q;

  logic                 cfg_load;
  logic [PKT_LEN_W-1:0] len0_in;
  logic [PKT_LEN_W-1:0] n_beats;
  logic [PKT_LEN_W:0]   len_sum;
  logic [PKT_LEN_W-1:0] len_next;
  logic                 more_after_pkt;
  logic                 more_in_gap;
  logic                 cancel_hit;
  state_t               after_pkt;
  logic [PKT_LEN_W-1:0] beat_x;
  logic [7:0]           byte_base;
  logic [LEN_W-1:0]     rem_keep;

  assign cfg_load  = (state_q == S_IDLE) && start_i;
  assign len0_in   = (cfg_len_i == '0) ? PKT_LEN_W'(1) : cfg_len_i;
  assign n_beats   = len_q / PKT_LEN_W'(KEEP_W);
  assign rem_keep  = LEN_W'(len_q % PKT_LEN_W'(KEEP_W));
  assign beat_x    = beat_q * PKT_LEN_W'(KEEP_W);
  assign byte_base = p_q[7:0] + beat_x[7:0];

  // Sweep wraps back to the base length on ceiling overrun or carry-out.
  assign len_sum  = {1'b0, len_q} + {1'b0, step_q};
  assign len_next = (len_sum[PKT_LEN_W] || (len_sum[PKT_LEN_W-1:0] > max_q))
                    ? len0_q : len_sum[PKT_LEN_W-1:0];

  // p has not yet advanced at packet end but has by the time GAP runs.
  assign more_after_pkt = ({1'b0, p_q} + CNT_ONE) < {1'b0, pkt_n_q};
  assign more_in_gap    = p_q < pkt_n_q;

  assign cancel_hit = (state_q == S_DATA) && cancel_en_q &&
                      (p_q == cancel_idx_q) && (beat_q == cancel_beat_q);

  // Where a finished or cancelled packet goes next; a zero gap skips GAP.
  always_comb begin
    after_pkt = S_GAP;
    if (gap_cfg_q == 8'd0) begin
      after_pkt = more_after_pkt ? S_REQ : S_DONE;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    p_d     = p_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    len_d   = len_q;
    sent_d  = sent_q;
    canc_d  = canc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          p_d     = '0;
          beat_d  = '0;
          len_d   = len0_in;
          state_d = (cfg_pkt_n_i == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (app_ready_v_i) begin
          beat_d  = '0;
          state_d = (n_beats == '0) ? S_LAST : S_DATA;
        end
      end
      S_DATA: begin
        if (cancel_hit) begin
          canc_d  = canc_q + CNT_W'(1);
          p_d     = p_q + CNT_W'(1);
          len_d   = len_next;
          gap_d   = gap_cfg_q;
          state_d = after_pkt;
        end else begin
          beat_d = beat_q + PKT_LEN_W'(1);
          if (beat_q == n_beats - PKT_LEN_W'(1)) begin
            state_d = S_LAST;
          end
        end
      end
      S_LAST: begin
        sent_d  = sent_q + CNT_W'(1);
        p_d     = p_q + CNT_W'(1);
        len_d   = len_next;
        gap_d   = gap_cfg_q;
        state_d = after_pkt;
      end
      S_GAP: begin
        if (gap_q == 8'd1) begin
          state_d = more_in_gap ? S_REQ : S_DONE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, packet index, beat/gap counters and statistics registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      canc_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      canc_q  <= canc_d;
    end
  end

  // Configuration shadow registers, loaded only when a burst is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_n_q       <= '0;
      len0_q        <= '0;
      step_q        <= '0;
      max_q         <= '0;
      gap_cfg_q     <= '0;
      cancel_en_q   <= 1'b0;
      cancel_idx_q  <= '0;
      cancel_beat_q <= '0;
    end else if (cfg_load) begin
      pkt_n_q       <= cfg_pkt_n_i;
      len0_q        <= len0_in;
      step_q        <= cfg_len_step_i;
      max_q         <= cfg_len_max_i;
      gap_cfg_q     <= cfg_gap_i;
      cancel_en_q   <= cfg_cancel_en_i;
      cancel_idx_q  <= cfg_cancel_idx_i;
      cancel_beat_q <= cfg_cancel_beat_i;
    end
  end

  // Application-side outputs decoded from state; everything idles at 0.
  always_comb begin
    app_early_v_o             = 1'b0;
    app_cancel_o              = 1'b0;
    app_data_o                = '0;
    app_len_o                 = '0;
    app_pkt_len_o             = '0;
    app_last_o                = 1'b0;
    app_last_block_next_o     = 1'b0;
    app_last_block_next_len_o = '0;
    unique case (state_q)
      S_REQ: begin
        app_early_v_o = 1'b1;
        app_pkt_len_o = len_q;
      end
      S_DATA: begin
        app_pkt_len_o = len_q;
        for (int j = 0; j < KEEP_W; j++) begin
          app_data_o[8*j +: 8] = byte_base + 8'(j);
        end
        if (cancel_hit) begin
          app_cancel_o = 1'b1;
        end else begin
          app_len_o = LEN_W'(KEEP_W);
          if ((beat_x % PKT_LEN_W'(BLOCK_N) == '0) &&
              (beat_x / PKT_LEN_W'(BLOCK_N) == len_q / PKT_LEN_W'(BLOCK_N))) begin
            app_last_block_next_o     = 1'b1;
            app_last_block_next_len_o = APP_LAST_LEN_W'(len_q % PKT_LEN_W'(BLOCK_N));
          end
        end
      end
      S_LAST: begin
        app_pkt_len_o = len_q;
        app_last_o    = 1'b1;
        app_len_o     = rem_keep;
        for (int j = 0; j < KEEP_W; j++) begin
          if (j < int'(rem_keep)) begin
            app_data_o[8*j +: 8] = byte_base + 8'(j);
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign app_cs_o     = '0;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign pkt_sent_o   = sent_q;
  assign pkt_cancel_o = canc_q;

endmodule

// File: tb/tb_eth_tx_app_gen.sv
// Scoreboard bench for eth_tx_app_gen (DATA_W=16). Stimulus pushes the
// expected requests/beats; a negedge monitor pops and compares them.
module tb_eth_tx_app_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [15:0] cfg_pkt_n_i, cfg_len_i, cfg_len_step_i, cfg_len_max_i;
  logic [7:0]  cfg_gap_i;
  logic        cfg_cancel_en_i;
  logic [15:0] cfg_cancel_idx_i, cfg_cancel_beat_i;
  logic        app_ready_v_i;
  logic        app_early_v_o, app_cancel_o, app_last_o, app_last_block_next_o;
  logic [15:0] app_data_o, app_pkt_len_o, app_cs_o;
  logic [1:0]  app_len_o;
  logic [3:0]  app_last_block_next_len_o;
  logic        busy_o, done_o;
  logic [15:0] pkt_sent_o, pkt_cancel_o;

  eth_tx_app_gen #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .cfg_pkt_n_i(cfg_pkt_n_i), .cfg_len_i(cfg_len_i),
    .cfg_len_step_i(cfg_len_step_i), .cfg_len_max_i(cfg_len_max_i),
    .cfg_gap_i(cfg_gap_i), .cfg_cancel_en_i(cfg_cancel_en_i),
    .cfg_cancel_idx_i(cfg_cancel_idx_i), .cfg_cancel_beat_i(cfg_cancel_beat_i),
    .app_early_v_o(app_early_v_o), .app_ready_v_i(app_ready_v_i),
    .app_cancel_o(app_cancel_o), .app_data_o(app_data_o), .app_len_o(app_len_o),
    .app_pkt_len_o(app_pkt_len_o), .app_cs_o(app_cs_o), .app_last_o(app_last_o),
    .app_last_block_next_o(app_last_block_next_o),
    .app_last_block_next_len_o(app_last_block_next_len_o),
    .busy_o(busy_o), .done_o(done_o),
    .pkt_sent_o(pkt_sent_o), .pkt_cancel_o(pkt_cancel_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        last;
    logic        lbn;
    logic [3:0]  lbn_len;
    logic        cancel;
    logic        chk_data;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_reqs[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_gap     = -1;
  int    exp_sent    = 0;
  int    exp_canc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares requests, beats and inter-packet idle time.
  logic  prev_early = 1'b0;
  logic  end_seen   = 1'b0;
  int    idle_cnt   = 0;
  beat_t eb;
  int    er;
  logic  beat_now;
  always @(negedge clk) begin
    if (reset) begin
      prev_early = 1'b0;
      end_seen   = 1'b0;
    end else begin
      beat_now = app_last_o || app_cancel_o || (app_len_o != 2'd0);
      if (app_early_v_o && !prev_early) begin
        if (exp_reqs.size() == 0) check("unexpected_req", 1, 0);
        else begin
          er = exp_reqs.pop_front();
          check("req_pkt_len", 64'(app_pkt_len_o), 64'(er));
        end
        if (end_seen && exp_gap >= 0) check("gap_idle_cycles", 64'(idle_cnt), 64'(exp_gap));
        end_seen = 1'b0;
      end else if (end_seen && !beat_now) begin
        idle_cnt++;
      end
      if (beat_now) begin
        if (exp_beats.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          eb = exp_beats.pop_front();
          check("beat_ctl",
                {app_len_o, app_last_o, app_last_block_next_o, app_last_block_next_len_o, app_cancel_o},
                {eb.len, eb.last, eb.lbn, eb.lbn_len, eb.cancel});
          if (eb.chk_data) check("beat_data", 64'(app_data_o), 64'(eb.data));
        end
        if (app_last_o || app_cancel_o) begin
          end_seen = 1'b1;
          idle_cnt = 0;
        end
      end
      if (done_o) end_seen = 1'b0;
      prev_early = app_early_v_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [15:0] d, input logic [1:0] l, input logic last,
                           input logic lbn, input logic [3:0] lbn_len);
    beat_t b;
    b = '{data: d, len: l, last: last, lbn: lbn, lbn_len: lbn_len, cancel: 1'b0, chk_data: 1'b1};
    exp_beats.push_back(b);
  endtask

  // Expected beats of one packet: byte k = p+k, blocks of 8, 2 bytes/beat.
  task automatic push_pkt(input int p, input int len, input int cbeat);
    beat_t b;
    int nb;
    int rem;
    logic lbn;
    nb = len / 2;
    for (int i = 0; i < nb; i++) begin
      if (i == cbeat) begin
        b = '{data: 16'h0, len: 2'd0, last: 1'b0, lbn: 1'b0, lbn_len: 4'd0, cancel: 1'b1, chk_data: 1'b0};
        exp_beats.push_back(b);
        return;
      end
      lbn = ((2 * i) % 8 == 0) && ((2 * i) / 8 == len / 8);
      push_beat({8'(p + 2 * i + 1), 8'(p + 2 * i)}, 2'd2, 1'b0, lbn, lbn ? 4'(len % 8) : 4'd0);
    end
    rem = len % 2;
    push_beat({8'h00, (rem != 0) ? 8'(p + 2 * nb) : 8'h00}, 2'(rem), 1'b1, 1'b0, 4'd0);
  endtask

  task automatic configure(input int pkt_n, input int len, input int step, input int lmax,
                           input int gap, input logic cen, input int cidx, input int cbeat);
    cfg_pkt_n_i       = 16'(pkt_n);
    cfg_len_i         = 16'(len);
    cfg_len_step_i    = 16'(step);
    cfg_len_max_i     = 16'(lmax);
    cfg_gap_i         = 8'(gap);
    cfg_cancel_en_i   = cen;
    cfg_cancel_idx_i  = 16'(cidx);
    cfg_cancel_beat_i = 16'(cbeat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_app"}, {app_early_v_o, app_cancel_o, app_data_o, app_len_o, app_pkt_len_o,
                          app_last_o, app_last_block_next_o, app_last_block_next_len_o}, 0);
    check({tag, "_status"}, {app_cs_o, busy_o, done_o, pkt_sent_o, pkt_cancel_o}, 0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    start_i = 1'b0;
    cyc();
    check_all_zero("reset");
    exp_beats.delete();
    exp_reqs.delete();
    exp_gap  = -1;
    exp_sent = 0;
    exp_canc = 0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic start_burst();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("start_latency", {app_early_v_o, busy_o}, 2'b11);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 64'(done_o), 1);
    cyc();
    check({name, "_idle"}, {busy_o, done_o}, 2'b00);
    check({name, "_sent"}, 64'(pkt_sent_o), 64'(exp_sent));
    check({name, "_canc"}, 64'(pkt_cancel_o), 64'(exp_canc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    app_ready_v_i = 1'b1;
    configure(0, 0, 0, 0, 0, 1'b0, 0, 0);
    do_reset();

    // len=5, hand-computed beats.
    configure(1, 5, 0, 16'hFFFF, 0, 1'b0, 0, 0);
    exp_reqs.push_back(5);
    push_beat(16'h0100, 2'd2, 1'b0, 1'b1, 4'd5);
    push_beat(16'h0302, 2'd2, 1'b0, 1'b0, 4'd0);
    push_beat(16'h0004, 2'd1, 1'b1, 1'b0, 4'd0);
    start_burst();
    exp_sent = 1;
    wait_done("len5");

    // len=12: last_block_next only on beat 4 with next_len 4.
    configure(1, 12, 0, 16'hFFFF, 0, 1'b0, 0, 0);
    exp_reqs.push_back(12);
    push_pkt(0, 12, -1);
    start_burst();
    exp_sent++;
    wait_done("len12");

    // len=16: no last_block_next, len0 last beat.
    configure(1, 16, 0, 16'hFFFF, 0, 1'b0, 0, 0);
    exp_reqs.push_back(16);
    push_pkt(0, 16, -1);
    start_burst();
    exp_sent++;
    wait_done("len16");

    // Length sweep 2,5,8,2 with two idle cycles between packets.
    configure(4, 2, 3, 8, 2, 1'b0, 0, 0);
    exp_gap = 2;
    exp_reqs.push_back(2); exp_reqs.push_back(5);
    exp_reqs.push_back(8); exp_reqs.push_back(2);
    push_pkt(0, 2, -1); push_pkt(1, 5, -1);
    push_pkt(2, 8, -1); push_pkt(3, 2, -1);
    start_burst();
    exp_sent += 4;
    wait_done("sweep");
    exp_gap = -1;

    // Ready held low: request persists, no data until after ready.
    configure(1, 4, 0, 16'hFFFF, 0, 1'b0, 0, 0);
    app_ready_v_i = 1'b0;
    exp_reqs.push_back(4);
    push_pkt(0, 4, -1);
    start_burst();
    for (int i = 0; i < 7; i++) begin
      check("ready_hold", {app_early_v_o, app_len_o, app_last_o}, {1'b1, 2'd0, 1'b0});
      cyc();
    end
    app_ready_v_i = 1'b1;
    cyc();
    check("first_beat_after_ready", {app_early_v_o, app_len_o}, {1'b0, 2'd2});
    exp_sent++;
    wait_done("ready");

    // Zero-packet burst finishes the next cycle.
    configure(0, 4, 0, 16'hFFFF, 0, 1'b0, 0, 0);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("zero_pkt_done", {done_o, busy_o, app_early_v_o}, 3'b110);
    cyc();
    check("zero_pkt_idle", {done_o, busy_o}, 2'b00);

    // Cancel beat beyond the data beats: no cancel.
    configure(1, 8, 0, 16'hFFFF, 0, 1'b1, 0, 4);
    exp_reqs.push_back(8);
    push_pkt(0, 8, -1);
    start_burst();
    exp_sent++;
    wait_done("cancel_oob");

    // Cancel on packet 1 beat 1 within a 3-packet burst.
    do_reset();
    configure(3, 8, 0, 8, 0, 1'b1, 1, 1);
    exp_gap = 0;
    for (int i = 0; i < 3; i++) exp_reqs.push_back(8);
    push_pkt(0, 8, -1); push_pkt(1, 8, 1); push_pkt(2, 8, -1);
    start_burst();
    exp_sent = 2;
    exp_canc = 1;
    wait_done("cancel");
    check("beats_drained", 64'(exp_beats.size()), 0);
    check("reqs_drained", 64'(exp_reqs.size()), 0);

    // Same burst, reset asserted mid-packet 2.
    do_reset();
    configure(3, 8, 0, 8, 0, 1'b1, 1, 1);
    exp_gap = 0;
    for (int i = 0; i < 3; i++) exp_reqs.push_back(8);
    push_pkt(0, 8, -1); push_pkt(1, 8, 1); push_pkt(2, 8, -1);
    start_burst();
    begin
      int n = 0;
      while (!app_cancel_o && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("cancel_seen", 64'(app_cancel_o), 1);
    end
    cyc();
    check("pkt2_req", 64'(app_early_v_o), 1);
    cyc();
    cyc();
    check("pkt2_mid", {busy_o, app_len_o, pkt_sent_o, pkt_cancel_o}, {1'b1, 2'd2, 16'd1, 16'd1});
    reset = 1'b1;
    cyc();
    check_all_zero("midpkt_reset");
    exp_beats.delete();
    exp_reqs.delete();
    exp_gap = -1;
    cyc();
    reset = 1'b0;
    cyc();
    check_all_zero("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
